// File: rtl/hmc_resp_pkg.sv
// Shared command/error codes, FSM state and delay-line entry type for the HMC responder.
// Command codes mirror hmc_def.vh so requesters and this responder agree on encodings.
package hmc_resp_pkg;

   localparam logic [3:0] HMC_CMD_WR = 4'b1000;
   localparam logic [3:0] HMC_CMD_RD = 4'b0000;

   localparam logic [6:0] ERR_NONE = 7'h00;
   localparam logic [6:0] ERR_SIZE = 7'h01;

   localparam int unsigned RESP_TAG_WIDTH  = 6;
   localparam int unsigned RESP_DATA_WIDTH = 128;

   typedef enum logic [0:0] {StIdle, StWaitWdata} resp_state_e;

   typedef struct packed {
      logic                       valid;
      logic [RESP_TAG_WIDTH-1:0]  tag;
      logic [RESP_DATA_WIDTH-1:0] data;
      logic                       dinv;
      logic [6:0]                 errstat;
   } dl_entry_t;

   // Configuration-time contents of store word idx.
   function automatic logic [RESP_DATA_WIDTH-1:0] cfg_word(input logic [31:0] idx);
      return {96'h0, idx};
   endfunction

endpackage

// File: rtl/hmc_wdata_fifo.sv
// Synchronous write-data FIFO with full/empty flags and a combinational head.
module hmc_wdata_fifo #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic                  rx_clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH_LOG2:0]   wr_ptr_q, rd_ptr_q;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                  (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
   assign head  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

   always_ff @(posedge rx_clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge rx_clk) begin
      if (push && !full) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
   end

endmodule

// File: rtl/hmc_mem_responder.sv
// HMC user-port responder: accepts RD/WR commands and write beats, serves a 128-bit
// on-chip store and returns tagged read data after a fixed latency.
module hmc_mem_responder
   import hmc_resp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH       = 34,
   parameter int unsigned TAG_WIDTH        = 6,
   parameter int unsigned SIZE_WIDTH       = 4,
   parameter int unsigned DATA_WIDTH       = 128,
   parameter int unsigned MEM_WORDS_LOG2   = 10,
   parameter int unsigned READ_LATENCY     = 8,
   parameter int unsigned WDATA_DEPTH_LOG2 = 2
) (
   input  logic                  rx_clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [3:0]            cmd,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [SIZE_WIDTH-1:0] size,
   input  logic [TAG_WIDTH-1:0]  tag,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_data_valid,
   output logic                  wr_data_ready,
   input  logic                  stall,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [TAG_WIDTH-1:0]  rd_data_tag,
   output logic                  rd_data_valid,
   output logic [6:0]            errstat,
   output logic                  dinv,
   output logic [31:0]           rd_count,
   output logic [31:0]           wr_count
);

   localparam int unsigned MEM_WORDS = 1 << MEM_WORDS_LOG2;

   resp_state_e                 state_q, state_d;
   logic [MEM_WORDS_LOG2-1:0]   wait_idx_q;
   logic [SIZE_WIDTH-1:0]       wait_size_q;
   logic [DATA_WIDTH-1:0]       mem_q [MEM_WORDS];
   dl_entry_t                   dl_q [READ_LATENCY];
   dl_entry_t                   dl_in;
   logic [31:0]                 rd_count_q, wr_count_q;

   logic [MEM_WORDS_LOG2-1:0]   cmd_idx, wr_idx;
   logic [SIZE_WIDTH-1:0]       wr_size;
   logic                        cmd_fire, rd_fire, rd_ok, wr_fire;
   logic                        beat_avail, consume, mem_we;
   logic [DATA_WIDTH-1:0]       beat_data;
   logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_WIDTH-1:0]       fifo_head;
   logic                        unused_addr;

   assign cmd_idx     = addr[4 +: MEM_WORDS_LOG2];
   assign unused_addr = ^{addr[3:0], addr[ADDR_WIDTH-1:4+MEM_WORDS_LOG2]};

   hmc_wdata_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (WDATA_DEPTH_LOG2)
   ) u_wdata_fifo (
      .rx_clk    (rx_clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (wr_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // FSM: state register
   always_ff @(posedge rx_clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:      if (wr_fire && !beat_avail) state_d = StWaitWdata;
         StWaitWdata: if (beat_avail)             state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      cmd_ready     = 1'b0;
      wr_data_ready = 1'b0;
      if (!rst) begin
         cmd_ready     = (state_q == StIdle) && !stall;
         wr_data_ready = !fifo_full;
      end
   end

   always_comb begin
      cmd_fire   = cmd_valid && cmd_ready;
      rd_fire    = cmd_fire && (cmd == HMC_CMD_RD);
      rd_ok      = rd_fire && (size == SIZE_WIDTH'(1));
      wr_fire    = cmd_fire && (cmd == HMC_CMD_WR);
      beat_avail = !fifo_empty || wr_data_valid;
      // Oldest beat wins; a same-cycle beat is bypassed only when nothing is queued.
      beat_data  = fifo_empty ? wr_data : fifo_head;
      consume    = !rst && beat_avail && (wr_fire || (state_q == StWaitWdata));
      wr_idx     = (state_q == StWaitWdata) ? wait_idx_q : cmd_idx;
      wr_size    = (state_q == StWaitWdata) ? wait_size_q : size;
      mem_we     = consume && (wr_size == SIZE_WIDTH'(1));
      fifo_pop   = consume && !fifo_empty;
      fifo_push  = wr_data_valid && wr_data_ready && !(consume && fifo_empty);
   end

   always_comb begin
      dl_in = '0;
      if (rd_fire) begin
         dl_in.valid = 1'b1;
         dl_in.tag   = RESP_TAG_WIDTH'(tag);
         if (rd_ok) begin
            dl_in.data    = RESP_DATA_WIDTH'(mem_q[cmd_idx]) ^ cfg_word(32'(cmd_idx));
            dl_in.errstat = ERR_NONE;
         end else begin
            dl_in.dinv    = 1'b1;
            dl_in.errstat = ERR_SIZE;
         end
      end
   end

   // Store holds data XOR its configuration pattern, so a zeroed array (BRAM power-up)
   // reads back as the configured contents; rst leaves it untouched.
   always_ff @(posedge rx_clk) begin
      if (mem_we) mem_q[wr_idx] <= beat_data ^ DATA_WIDTH'(cfg_word(32'(wr_idx)));
   end

   always_ff @(posedge rx_clk) begin
      if (rst) begin
         wait_idx_q  <= '0;
         wait_size_q <= '0;
         rd_count_q  <= '0;
         wr_count_q  <= '0;
      end else begin
         if (state_q == StIdle && wr_fire && !beat_avail) begin
            wait_idx_q  <= cmd_idx;
            wait_size_q <= size;
         end
         if (rd_ok)  rd_count_q <= rd_count_q + 32'd1;
         if (mem_we) wr_count_q <= wr_count_q + 32'd1;
      end
   end

   always_ff @(posedge rx_clk) begin
      if (rst) begin
         for (int i = 0; i < READ_LATENCY; i++) dl_q[i] <= '0;
      end else begin
         dl_q[0] <= dl_in;
         for (int i = 1; i < READ_LATENCY; i++) dl_q[i] <= dl_q[i-1];
      end
   end

   assign rd_data_valid = dl_q[READ_LATENCY-1].valid;
   assign rd_data       = DATA_WIDTH'(dl_q[READ_LATENCY-1].data);
   assign rd_data_tag   = TAG_WIDTH'(dl_q[READ_LATENCY-1].tag);
   assign dinv          = dl_q[READ_LATENCY-1].dinv;
   assign errstat       = dl_q[READ_LATENCY-1].errstat;
   assign rd_count      = rd_count_q;
   assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_hmc_mem_responder.sv
// Directed self-checking bench for hmc_mem_responder: latency, bypass/queued writes,
// WAIT_WDATA stall, streaming reads, size errors, FIFO full and mid-operation reset.
module tb_hmc_mem_responder;
   import hmc_resp_pkg::*;

   logic         rx_clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [3:0]   cmd;
   logic [33:0]  addr;
   logic [3:0]   size;
   logic [5:0]   tag;
   logic [127:0] wr_data;
   logic         wr_data_valid;
   logic         wr_data_ready;
   logic         stall;
   logic [127:0] rd_data;
   logic [5:0]   rd_data_tag;
   logic         rd_data_valid;
   logic [6:0]   errstat;
   logic         dinv;
   logic [31:0]  rd_count;
   logic [31:0]  wr_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [127:0] q_data[$];
   logic [5:0]   q_tag[$];
   logic         q_dinv[$];
   logic [6:0]   q_err[$];
   int           q_cyc[$];

   logic [127:0] exp_mem [1024];
   logic [127:0] beats [5];

   hmc_mem_responder u_dut (
      .rx_clk        (rx_clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd           (cmd),
      .addr          (addr),
      .size          (size),
      .tag           (tag),
      .wr_data       (wr_data),
      .wr_data_valid (wr_data_valid),
      .wr_data_ready (wr_data_ready),
      .stall         (stall),
      .rd_data       (rd_data),
      .rd_data_tag   (rd_data_tag),
      .rd_data_valid (rd_data_valid),
      .errstat       (errstat),
      .dinv          (dinv),
      .rd_count      (rd_count),
      .wr_count      (wr_count)
   );

   always #5 rx_clk = ~rx_clk;

   always @(posedge rx_clk) cyc <= cyc + 1;

   always @(negedge rx_clk) begin
      if (rd_data_valid === 1'b1) begin
         q_data.push_back(rd_data);
         q_tag.push_back(rd_data_tag);
         q_dinv.push_back(dinv);
         q_err.push_back(errstat);
         q_cyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge rx_clk);
      #1;
   endtask

   task automatic cmd_drive(input logic [3:0] c, input logic [33:0] a, input logic [3:0] s,
                            input logic [5:0] t);
      cmd_valid = 1'b1;
      cmd       = c;
      addr      = a;
      size      = s;
      tag       = t;
   endtask

   task automatic clear_q();
      q_data.delete();
      q_tag.delete();
      q_dinv.delete();
      q_err.delete();
      q_cyc.delete();
   endtask

   task automatic wait_resps(input int n, input int max_cyc);
      int k = 0;
      while (q_tag.size() < n && k < max_cyc) begin
         next_cycle();
         k++;
      end
      check_eq("resp_count", 128'(q_tag.size()), 128'(n));
   endtask

   initial begin
      int t0;
      for (int i = 0; i < 1024; i++) exp_mem[i] = {96'h0, 32'(i)};
      beats[0] = 128'h0000_0000_DEAD_BEEF_0000_0000_0000_00C1;
      beats[1] = 128'hC2C2_0000_0000_0000_0000_0000_0000_00C2;
      beats[2] = 128'h0000_00C3_0000_0000_0000_0000_0000_00C3;
      beats[3] = 128'h0000_0000_0000_0000_C4C4_C4C4_0000_00C4;
      beats[4] = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;
      rst = 1'b1; cmd_valid = 1'b0; cmd = 4'h0; addr = '0; size = 4'd1; tag = '0;
      wr_data = '0; wr_data_valid = 1'b0; stall = 1'b0;

      // Reset values
      repeat (3) next_cycle();
      @(negedge rx_clk);
      check_eq("rst_cmd_ready", 128'(cmd_ready), 128'(0));
      check_eq("rst_wr_data_ready", 128'(wr_data_ready), 128'(0));
      check_eq("rst_rd_valid", 128'(rd_data_valid), 128'(0));
      check_eq("rst_rd_data", rd_data, 128'(0));
      check_eq("rst_rd_count", 128'(rd_count), 128'(0));
      check_eq("rst_wr_count", 128'(wr_count), 128'(0));
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // Stall gates cmd_ready
      stall = 1'b1;
      cmd_drive(HMC_CMD_RD, 34'h30, 4'd1, 6'd5);
      @(negedge rx_clk);
      check_eq("stall_cmd_ready", 128'(cmd_ready), 128'(0));
      next_cycle();
      stall = 1'b0;
      cmd_valid = 1'b0;
      next_cycle();

      // Basic read latency
      clear_q();
      cmd_drive(HMC_CMD_RD, 34'h30, 4'd1, 6'd5);
      t0 = cyc;
      next_cycle();
      cmd_valid = 1'b0;
      wait_resps(1, 20);
      if (q_tag.size() >= 1) begin
         check_eq("rd1_latency", 128'(q_cyc[0] - t0), 128'(8));
         check_eq("rd1_data", q_data[0], 128'h3);
         check_eq("rd1_tag", 128'(q_tag[0]), 128'(5));
         check_eq("rd1_dinv", 128'(q_dinv[0]), 128'(0));
         check_eq("rd1_errstat", 128'(q_err[0]), 128'(0));
      end
      check_eq("rd1_rd_count", 128'(rd_count), 128'(1));

      // Write with same-cycle beat (bypass), then read back
      clear_q();
      cmd_drive(HMC_CMD_WR, 34'h40, 4'd1, 6'd0);
      wr_data = 128'hA5;
      wr_data_valid = 1'b1;
      @(negedge rx_clk);
      check_eq("bypass_wr_data_ready", 128'(wr_data_ready), 128'(1));
      next_cycle();
      exp_mem[4] = 128'hA5;
      wr_data_valid = 1'b0;
      cmd_drive(HMC_CMD_RD, 34'h40, 4'd1, 6'd7);
      next_cycle();
      cmd_valid = 1'b0;
      wait_resps(1, 20);
      repeat (4) next_cycle();
      check_eq("wr_no_resp", 128'(q_tag.size()), 128'(1));
      if (q_tag.size() >= 1) begin
         check_eq("rd2_data", q_data[0], 128'hA5);
         check_eq("rd2_tag", 128'(q_tag[0]), 128'(7));
      end
      check_eq("wr2_wr_count", 128'(wr_count), 128'(1));

      // Write without data: WAIT_WDATA for 3 cycles
      clear_q();
      cmd_drive(HMC_CMD_WR, 34'h50, 4'd1, 6'd0);
      next_cycle();
      cmd_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         wr_data_valid = (k == 3);
         wr_data = 128'hBEEF;
         @(negedge rx_clk);
         check_eq($sformatf("wait_cmd_ready_%0d", k), 128'(cmd_ready), 128'(k == 4));
         next_cycle();
      end
      exp_mem[5] = 128'hBEEF;
      wr_data_valid = 1'b0;
      cmd_drive(HMC_CMD_RD, 34'h50, 4'd1, 6'd11);
      next_cycle();
      cmd_valid = 1'b0;
      wait_resps(1, 20);
      if (q_tag.size() >= 1) check_eq("rd3_data", q_data[0], 128'hBEEF);
      check_eq("wr3_wr_count", 128'(wr_count), 128'(2));

      // 32 back-to-back reads
      clear_q();
      t0 = cyc;
      for (int i = 0; i < 32; i++) begin
         cmd_drive(HMC_CMD_RD, 34'(i * 16), 4'd1, 6'(i));
         next_cycle();
      end
      cmd_valid = 1'b0;
      wait_resps(32, 60);
      for (int i = 0; i < 32 && i < q_tag.size(); i++) begin
         check_eq($sformatf("stream_tag_%0d", i), 128'(q_tag[i]), 128'(i));
         check_eq($sformatf("stream_data_%0d", i), q_data[i], exp_mem[i]);
         check_eq($sformatf("stream_cyc_%0d", i), 128'(q_cyc[i] - t0), 128'(8 + i));
      end
      check_eq("stream_rd_count", 128'(rd_count), 128'(35));

      // Bad-size read
      clear_q();
      cmd_drive(HMC_CMD_RD, 34'h10, 4'd2, 6'd9);
      next_cycle();
      cmd_valid = 1'b0;
      wait_resps(1, 20);
      if (q_tag.size() >= 1) begin
         check_eq("badsz_tag", 128'(q_tag[0]), 128'(9));
         check_eq("badsz_dinv", 128'(q_dinv[0]), 128'(1));
         check_eq("badsz_errstat", 128'(q_err[0]), 128'h01);
         check_eq("badsz_data", q_data[0], 128'h0);
      end

      // Fill the FIFO without a WR: 5th beat refused
      for (int k = 0; k < 5; k++) begin
         wr_data_valid = 1'b1;
         wr_data = beats[k];
         @(negedge rx_clk);
         check_eq($sformatf("fifo_ready_%0d", k), 128'(wr_data_ready), 128'(k < 4));
         next_cycle();
      end
      wr_data_valid = 1'b0;

      // Two writes drain the two oldest beats in order
      clear_q();
      cmd_drive(HMC_CMD_WR, 34'h60, 4'd1, 6'd0);
      next_cycle();
      cmd_drive(HMC_CMD_WR, 34'h70, 4'd1, 6'd0);
      next_cycle();
      cmd_valid = 1'b0;
      exp_mem[6] = beats[0];
      exp_mem[7] = beats[1];
      @(negedge rx_clk);
      check_eq("fifo_ready_after_pop", 128'(wr_data_ready), 128'(1));
      next_cycle();
      cmd_drive(HMC_CMD_RD, 34'h60, 4'd1, 6'd20);
      next_cycle();
      cmd_drive(HMC_CMD_RD, 34'h70, 4'd1, 6'd21);
      next_cycle();
      cmd_valid = 1'b0;
      wait_resps(2, 20);
      if (q_tag.size() >= 2) begin
         check_eq("fifo_order_0", q_data[0], exp_mem[6]);
         check_eq("fifo_order_1", q_data[1], exp_mem[7]);
      end
      check_eq("fifo_rd_count", 128'(rd_count), 128'(37));
      check_eq("fifo_wr_count", 128'(wr_count), 128'(4));

      // Reset with reads in flight and two beats still queued
      clear_q();
      cmd_drive(HMC_CMD_RD, 34'h60, 4'd1, 6'd1);
      next_cycle();
      cmd_drive(HMC_CMD_RD, 34'h70, 4'd1, 6'd2);
      next_cycle();
      cmd_drive(HMC_CMD_RD, 34'h00, 4'd1, 6'd3);
      next_cycle();
      cmd_valid = 1'b0;
      next_cycle();
      rst = 1'b1;
      @(negedge rx_clk);
      check_eq("midrst_cmd_ready", 128'(cmd_ready), 128'(0));
      check_eq("midrst_wr_data_ready", 128'(wr_data_ready), 128'(0));
      next_cycle();
      next_cycle();
      rst = 1'b0;
      repeat (15) next_cycle();
      check_eq("midrst_no_resp", 128'(q_tag.size()), 128'(0));
      check_eq("midrst_rd_count", 128'(rd_count), 128'(0));
      check_eq("midrst_wr_count", 128'(wr_count), 128'(0));

      // FIFO was emptied: a WR without a beat must wait
      cmd_drive(HMC_CMD_WR, 34'h80, 4'd1, 6'd0);
      next_cycle();
      cmd_valid = 1'b0;
      @(negedge rx_clk);
      check_eq("midrst_fifo_flushed", 128'(cmd_ready), 128'(0));
      wr_data = 128'hD1D1;
      wr_data_valid = 1'b1;
      next_cycle();
      wr_data_valid = 1'b0;
      exp_mem[8] = 128'hD1D1;
      cmd_drive(HMC_CMD_RD, 34'h60, 4'd1, 6'd30);
      next_cycle();
      cmd_drive(HMC_CMD_RD, 34'h80, 4'd1, 6'd31);
      next_cycle();
      cmd_valid = 1'b0;
      wait_resps(2, 20);
      if (q_tag.size() >= 2) begin
         check_eq("retained_data", q_data[0], exp_mem[6]);
         check_eq("post_rst_wr_data", q_data[1], exp_mem[8]);
      end
      check_eq("post_rst_rd_count", 128'(rd_count), 128'(2));
      check_eq("post_rst_wr_count", 128'(wr_count), 128'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hmc_mem_responder.md
# hmc_mem_responder

Synthesizable HMC port responder: the memory-side end of the user-port command/data interface driven by the GUPS-style requesters. It accepts read and write commands plus write-data beats and returns tagged read data after a fixed latency from an on-chip 128-bit backing store. It stands in for the HMC controller port in simulation and FPGA loopback builds, so requester logic can be exercised without a trained cube.

## Interface
- ADDR_WIDTH, 34, byte address width of cmd addr
- TAG_WIDTH, 6, tag width
- SIZE_WIDTH, 4, size field width
- DATA_WIDTH, 128, FLIT data width (fixed at 128)
- MEM_WORDS_LOG2, 10, log2 of backing-store depth in 16-byte words
- READ_LATENCY, 8, accept-to-response cycles (must be ≥1)
- WDATA_DEPTH_LOG2, 2, log2 of write-data FIFO depth
- rx_clk  in  1  clock; all logic single-clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd  in  4  HMC_CMD_RD / HMC_CMD_WR encodings from hmc_def.vh
- addr  in  ADDR_WIDTH  byte address; bits [3:0] ignored
- size  in  SIZE_WIDTH  FLIT count; only 1 supported
- tag  in  TAG_WIDTH  request tag
- wr_data  in  DATA_WIDTH  write payload
- wr_data_valid  in  1  payload present
- wr_data_ready  out  1  payload accepted when high with wr_data_valid
- stall  in  1  bench/debug throttle; forces cmd_ready low
- rd_data  out  DATA_WIDTH  response payload
- rd_data_tag  out  TAG_WIDTH  response tag
- rd_data_valid  out  1  single-cycle response strobe; no backpressure
- errstat  out  7  error code, qualified by rd_data_valid
- dinv  out  1  response data invalid, qualified by rd_data_valid
- rd_count, wr_count  out  32 each  accepted read / executed write totals

## Operation
- Word index = addr[4 +: MEM_WORDS_LOG2]; higher address bits are ignored, so addresses wrap modulo depth.
- Store is not cleared by rst. Configuration-time contents: word i = {96'h0, 32'(i)}.
- FSM states: IDLE, WAIT_WDATA.
- IDLE: cmd_ready = !stall.
- Accepted RD, size==1: read the word and enter the response delay line with the tag. errstat=0, dinv=0. rd_count += 1.
- Accepted RD, size!=1: response still issued after the same latency, with data 0, dinv=1, errstat=7'h01.
- Accepted WR with write data available: pop the write-data FIFO head, or bypass the same-cycle beat if the FIFO is empty. Write the word; wr_count += 1. Writes are posted and produce no response.
- Accepted WR with no data available: latch addr and size, then enter WAIT_WDATA.
- WAIT_WDATA: cmd_ready=0. The first available beat completes the write; return to IDLE that cycle.
- Accepted WR, size!=1: consumes one beat, discards it, no store update, wr_count unchanged.
- Unknown cmd code: accepted and dropped, no response.
- Write-data FIFO: wr_data_ready = !full. Beats are consumed in arrival order. A beat is never consumed without a WR.
- Counters wrap at 2^32.

## Timing
- RD accepted in cycle N → rd_data_valid high in cycle N+READ_LATENCY, exactly one cycle. Responses stay in acceptance order; one read per cycle gives full throughput.
- Write executed in cycle N is visible to a RD accepted in cycle N+1 or later. RD and WR are never accepted in the same cycle.
- Reset values: cmd_ready=0 during rst, rd_data=0, rd_data_tag=0, rd_data_valid=0, errstat=0, dinv=0, rd_count=0, wr_count=0, wr_data_ready=0 during rst, FSM=IDLE.
- Reset mid-operation: delay line flushed (in-flight reads dropped, never emitted), write-data FIFO emptied, latched WR discarded. Store contents retained.
- Bypass case, WR and beat in the same cycle with the FIFO empty: the beat is not enqueued, and wr_data_ready stays high that cycle.
- FIFO full while in WAIT_WDATA cannot occur: the head beat is consumed first.

## Structure
- Shared package hmc_resp_pkg:
  - command codes re-exported from hmc_def.vh
  - errstat codes ERR_NONE=7'h00, ERR_SIZE=7'h01
  - FSM state typedef
  - delay-line entry struct {valid, tag, data, dinv, errstat}
- One sub-module, hmc_wdata_fifo: synchronous FIFO, DATA_WIDTH wide, 2^WDATA_DEPTH_LOG2 deep, with full/empty flags. The delay line and store stay inline.

## Test plan
- Reset, then RD addr=0x30 tag=5 at cycle N → rd_data_valid at N+8, rd_data=128'h3, tag=5, dinv=0, rd_count=1.
- WR addr=0x40 with same-cycle beat 128'hA5, then RD addr=0x40 one cycle later → response data 128'hA5, wr_count=1, no response generated for the write.
- WR cmd with no beat; beat arrives 3 cycles later → cmd_ready low for exactly those cycles, store updated on beat arrival.
- 32 back-to-back RDs with tags 0..31 → 32 consecutive strobes in tag order, no gaps.
- RD size=2 tag=9 → response with dinv=1, errstat=7'h01, data 0. Then 4 beats pushed before any WR → wr_data_ready drops on the 5th beat.
- rst asserted while 3 reads are in flight → no rd_data_valid after reset, counters 0, a subsequent RD of a previously written address still returns the written data.
